core_sequencer: RTL and testbench

// - Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback

---
 rtl/core_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_core_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for an RV32I core.
// It steps each instruction through FETCH, DECODE, EXEC, optional MEM,
// and WB. Instruction fetch and load/store share one bus port.
// A bus wait that runs too long, or an illegal opcode, puts the FSM
// into a sticky FAULT state. The FSM also counts retired instructions.
module core_sequencer #(
  parameter int BUS_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             clear_fault,
  input  logic [1:0]       dec_mem_op,
  input  logic             dec_reg_we,
  input  logic             dec_illegal,
  input  logic             bus_ready,
  output logic             bus_req,
  output logic             bus_we,
  output logic             bus_addr_sel,
  output logic             ir_we,
  output logic             mem_data_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             busy,
  output logic [2:0]       state,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instret
);

  // The wait counter must be wide enough to hold the limit value itself.
  localparam int TO_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ILLEGAL = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [TO_W-1:0]  to_cnt;
  logic             store_op;
  logic [1:0]       fault_r;
  logic [CNT_W-1:0] instret_r;
  logic             bus_phase;
  logic             mem_access;
  logic             bus_wait;
  logic             timeout_hit;

  // Classify the decoded memory op and detect a bus wait that reaches the limit.
  // A ready on the limit cycle is not a wait, so the ready wins.
  always_comb begin
    bus_phase   = (cur_state == S_FETCH) || (cur_state == S_MEM);
    mem_access  = (dec_mem_op == 2'b01) || (dec_mem_op == 2'b10);
    bus_wait    = bus_phase && !bus_ready;
    timeout_hit = (BUS_TIMEOUT != 0) && bus_wait &&
                  ((int'(to_cnt) + 1) >= BUS_TIMEOUT);
  end

  // State register; an asynchronous reset drops any bus request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Bus wait counter: it restarts on each new bus phase and saturates,
  // so it cannot wrap while the timeout is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if ((nxt_state != cur_state) &&
                 ((nxt_state == S_FETCH) || (nxt_state == S_MEM))) begin
      to_cnt <= '0;
    end else if (bus_wait && (to_cnt != {TO_W{1'b1}})) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Latch the store/load direction in EXEC so that bus_we is a pure
  // state decode for the whole MEM phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_op <= 1'b0;
    end else if (cur_state == S_EXEC) begin
      store_op <= (dec_mem_op == 2'b10);
    end
  end

  // Fault code: it is set on the same edge that enters FAULT and cleared
  // on the same edge that leaves FAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r <= FC_NONE;
    end else if ((cur_state == S_DECODE) && dec_illegal) begin
      fault_r <= FC_ILLEGAL;
    end else if (timeout_hit) begin
      fault_r <= FC_TIMEOUT;
    end else if ((cur_state == S_FAULT) && clear_fault) begin
      fault_r <= FC_NONE;
    end
  end

  // Retired-instruction counter: it advances once per WB cycle and wraps
  // naturally. It only counts instructions that reach WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= '0;
    end else if (cur_state == S_WB) begin
      instret_r <= instret_r + CNT_W'(1);
    end
  end

  // Next-state logic and state-decoded strobes. ir_we and mem_data_we
  // also qualify on bus_ready, and rf_we follows dec_reg_we in WB.
  always_comb begin
    nxt_state    = cur_state;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr_sel = 1'b0;
    ir_we        = 1'b0;
    mem_data_we  = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (start) nxt_state = S_FETCH;
      end
      S_FETCH: begin
        bus_req = 1'b1;
        ir_we   = bus_ready;
        if (bus_ready)        nxt_state = S_DECODE;
        else if (timeout_hit) nxt_state = S_FAULT;
      end
      S_DECODE: begin
        nxt_state = dec_illegal ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        nxt_state = mem_access ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus_req      = 1'b1;
        bus_addr_sel = 1'b1;
        bus_we       = store_op;
        mem_data_we  = bus_ready && !store_op;
        if (bus_ready)        nxt_state = S_WB;
        else if (timeout_hit) nxt_state = S_FAULT;
      end
      S_WB: begin
        rf_we     = dec_reg_we;
        pc_we     = 1'b1;
        nxt_state = halt_req ? S_IDLE : S_FETCH;
      end
      S_FAULT: begin
        if (clear_fault) nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Status outputs are straight decodes of the registered state.
  always_comb begin
    busy       = (cur_state != S_IDLE) && (cur_state != S_FAULT);
    state      = cur_state;
    fault_code = fault_r;
    instret    = instret_r;
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer. Each instruction is described by its memory
// op, register write, illegal flag, bus wait counts and halt request. Every
// instruction expands into a per-cycle script that holds both the inputs to
// apply and the outputs expected. A compare process checks each cycle.
module tb_core_sequencer;
  localparam int TO = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, halt_req = 1'b0, clear_fault = 1'b0;
  logic [1:0]    dec_mem_op = 2'b00;
  logic          dec_reg_we = 1'b0, dec_illegal = 1'b0, bus_ready = 1'b0;
  logic          bus_req, bus_we, bus_addr_sel, ir_we, mem_data_we, rf_we, pc_we, busy;
  logic [2:0]    state;
  logic [1:0]    fault_code;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  core_sequencer #(.BUS_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .clear_fault(clear_fault), .dec_mem_op(dec_mem_op), .dec_reg_we(dec_reg_we),
    .dec_illegal(dec_illegal), .bus_ready(bus_ready), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr_sel(bus_addr_sel), .ir_we(ir_we),
    .mem_data_we(mem_data_we), .rf_we(rf_we), .pc_we(pc_we), .busy(busy),
    .state(state), .fault_code(fault_code), .instret(instret)
  );

  typedef struct {
    logic start, halt, clr, rwe, ill, rdy;
    logic [1:0] mop;
    logic breq, bwe, asel, irwe, mdwe, rfwe, pcwe, bsy;
    logic [2:0] st;
    logic [1:0] fc;
    logic [CW-1:0] ir;
  } cyc_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  cyc_t exp_c;
  bit   chk_en = 1'b0;
  int   m_instret = 0;
  int   m_fc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("state",        32'(state),        32'(exp_c.st));
      check("fault_code",   32'(fault_code),   32'(exp_c.fc));
      check("instret",      32'(instret),      32'(exp_c.ir));
      check("busy",         32'(busy),         32'(exp_c.bsy));
      check("bus_req",      32'(bus_req),      32'(exp_c.breq));
      check("bus_we",       32'(bus_we),       32'(exp_c.bwe));
      check("bus_addr_sel", 32'(bus_addr_sel), 32'(exp_c.asel));
      check("ir_we",        32'(ir_we),        32'(exp_c.irwe));
      check("mem_data_we",  32'(mem_data_we),  32'(exp_c.mdwe));
      check("rf_we",        32'(rf_we),        32'(exp_c.rfwe));
      check("pc_we",        32'(pc_we),        32'(exp_c.pcwe));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // A cycle in a given state: don't-care inputs are random, and all outputs
  // default to quiet.
  function automatic cyc_t base(input logic [2:0] st);
    cyc_t c;
    c.start = 1'($urandom_range(0, 1));
    c.halt  = 1'($urandom_range(0, 1));
    c.clr   = 1'($urandom_range(0, 1));
    c.rwe   = 1'($urandom_range(0, 1));
    c.ill   = 1'($urandom_range(0, 1));
    c.rdy   = 1'($urandom_range(0, 1));
    c.mop   = 2'($urandom_range(0, 3));
    c.breq = 0; c.bwe = 0; c.asel = 0; c.irwe = 0; c.mdwe = 0; c.rfwe = 0; c.pcwe = 0;
    c.st  = st;
    c.bsy = (st != 3'd0) && (st != 3'd6);
    c.fc  = 2'd0;
    c.ir  = CW'(m_instret);
    return c;
  endfunction

  task automatic emit(input cyc_t c);
    @(negedge clk);
    start = c.start; halt_req = c.halt; clear_fault = c.clr;
    dec_mem_op = c.mop; dec_reg_we = c.rwe; dec_illegal = c.ill; bus_ready = c.rdy;
    exp_c  = c;
    chk_en = 1'b1;
  endtask

  task automatic go(input int n_idle);
    cyc_t c;
    for (int k = 0; k < n_idle; k++) begin
      c = base(3'd0); c.start = 1'b0; emit(c);
    end
    c = base(3'd0); c.start = 1'b1; emit(c);
  endtask

  task automatic fault(input int code);
    cyc_t c;
    m_fc = code;
    c = base(3'd6); c.clr = 1'b0; c.fc = 2'(code); emit(c);
  endtask

  task automatic fault_clear(input int n);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c = base(3'd6); c.clr = 1'b0; c.fc = 2'(m_fc); emit(c);
    end
    c = base(3'd6); c.clr = 1'b1; c.fc = 2'(m_fc); emit(c);
    m_fc = 0;
  endtask

  task automatic run_instr(input logic [1:0] mop, input logic rwe, input logic ill,
                           input int wf, input int wm, input logic halt, output bit to_idle);
    cyc_t c;
    bit   is_mem;
    to_idle = 1'b0;
    is_mem  = (mop == 2'b01) || (mop == 2'b10);
    for (int k = 0; k < wf && k < TO; k++) begin
      c = base(3'd1); c.rdy = 1'b0; c.breq = 1'b1; emit(c);
    end
    if (wf >= TO) begin fault(2); to_idle = 1'b1; return; end
    c = base(3'd1); c.rdy = 1'b1; c.breq = 1'b1; c.irwe = 1'b1; emit(c);
    c = base(3'd2); c.mop = mop; c.rwe = rwe; c.ill = ill; emit(c);
    if (ill) begin fault(1); to_idle = 1'b1; return; end
    c = base(3'd3); c.mop = mop; c.rwe = rwe; c.ill = 1'b0; emit(c);
    if (is_mem) begin
      for (int k = 0; k < wm && k < TO; k++) begin
        c = base(3'd4); c.mop = mop; c.rwe = rwe; c.ill = 1'b0; c.rdy = 1'b0;
        c.breq = 1'b1; c.asel = 1'b1; c.bwe = (mop == 2'b10); emit(c);
      end
      if (wm >= TO) begin fault(2); to_idle = 1'b1; return; end
      c = base(3'd4); c.mop = mop; c.rwe = rwe; c.ill = 1'b0; c.rdy = 1'b1;
      c.breq = 1'b1; c.asel = 1'b1; c.bwe = (mop == 2'b10); c.mdwe = (mop == 2'b01);
      emit(c);
    end
    c = base(3'd5); c.mop = mop; c.rwe = rwe; c.ill = 1'b0; c.halt = halt;
    c.rfwe = rwe; c.pcwe = 1'b1; emit(c);
    m_instret = (m_instret + 1) % (1 << CW);
    to_idle = halt;
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(TO, TO + 2));
    return int'($urandom_range(0, TO - 1));
  endfunction

  initial begin
    bit   ti;
    bit   at_idle;
    cyc_t c;
    repeat (2) @(negedge clk);
    #2;
    check("lit_reset_state",   32'(state),      32'd0);
    check("lit_reset_bus_req", 32'(bus_req),    32'd0);
    check("lit_reset_instret", 32'(instret),    32'd0);
    check("lit_reset_fault",   32'(fault_code), 32'd0);
    rst_n = 1'b1;

    go(1);
    run_instr(2'b00, 1'b1, 1'b0, 0, 0, 1'b0, ti);
    #2;
    check("lit_alu_rf_we", 32'(rf_we), 32'd1);
    check("lit_alu_pc_we", 32'(pc_we), 32'd1);
    run_instr(2'b01, 1'b1, 1'b0, 0, 3, 1'b0, ti);
    #2;
    check("lit_load_wb_instret", 32'(instret), 32'd1);
    check("lit_load_wb_rf_we",   32'(rf_we),   32'd1);
    run_instr(2'b10, 1'b0, 1'b0, 1, 0, 1'b0, ti);
    #2;
    check("lit_store_rf_we", 32'(rf_we), 32'd0);
    check("lit_store_pc_we", 32'(pc_we), 32'd1);
    run_instr(2'b00, 1'b1, 1'b0, 9, 0, 1'b0, ti);
    #2;
    check("lit_timeout_state", 32'(state),      32'd6);
    check("lit_timeout_code",  32'(fault_code), 32'd2);
    fault_clear(2);
    go(0);
    #2;
    check("lit_cleared_state", 32'(state),      32'd0);
    check("lit_cleared_code",  32'(fault_code), 32'd0);
    run_instr(2'b00, 1'b1, 1'b1, 0, 0, 1'b0, ti);
    #2;
    check("lit_illegal_code",    32'(fault_code), 32'd1);
    check("lit_illegal_instret", 32'(instret),    32'd3);
    fault_clear(1);
    go(0);
    run_instr(2'b00, 1'b1, 1'b0, 0, 0, 1'b1, ti);
    c = base(3'd0); c.start = 1'b0; emit(c);
    #2;
    check("lit_halt_state",   32'(state),   32'd0);
    check("lit_halt_instret", 32'(instret), 32'd4);

    // Assert reset in the middle of a waiting fetch, away from a clock edge.
    go(0);
    c = base(3'd1); c.rdy = 1'b0; c.breq = 1'b1; emit(c);
    #3;
    rst_n  = 1'b0;
    chk_en = 1'b0;
    #1;
    check("lit_midreset_bus_req", 32'(bus_req), 32'd0);
    check("lit_midreset_state",   32'(state),   32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("lit_midreset_instret", 32'(instret), 32'd0);
    rst_n     = 1'b1;
    m_instret = 0;
    m_fc      = 0;

    at_idle = 1'b1;
    for (int i = 0; i < 420; i++) begin
      if (at_idle) go(int'($urandom_range(0, 2)));
      run_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 11) == 0), pick_wait(), pick_wait(),
                1'($urandom_range(0, 7) == 0), ti);
      if (ti && m_fc != 0) fault_clear(int'($urandom_range(0, 3)));
      at_idle = ti;
    end
    @(negedge clk);
    chk_en = 1'b0;
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
